act_unit_arbiter: RTL and testbench

- Round-robin arbiter sharing one activation unit between NUM_REQ layer requesters.
- The activation unit is the element-serial int32 -> float -> scale -> tanh -> int8 pipeline.
- Grants whole bursts (one layer vector, terminated by req_last) to one requester at a time.
- Tags every issued element and routes each int8 result back to its owner, in order.

---
 rtl/act_unit_arbiter_pkg.sv | 44 ++++
 rtl/act_unit_arbiter_tag_fifo.sv | 71 +++++++
 rtl/act_unit_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_act_unit_arbiter.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/act_unit_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// act_arb_pkg
// Shared types and helpers for the activation-unit arbiter.
//   arb_state_t : arbiter FSM state encoding
//   tag_width() : bits needed to tag an element with its requester index
//   rr_pick()   : round-robin search from a pointer upward with wrap
// -----------------------------------------------------------------------------
package act_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        BURST = 2'd2
    } arb_state_t;

    // Requester vectors are zero-extended to this width before searching.
    localparam int MAX_REQ = 8;

    function automatic int tag_width(input int num_req);
        return $clog2(num_req);
    endfunction

    // First index with valid set, searching ptr, ptr+1, ... wrapping at
    // num_req. Iterating from the far end lets the nearest match win.
    // Returns ptr when nothing is valid.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                           input logic [2:0]         ptr,
                                           input int                 num_req);
        int s;
        rr_pick = ptr;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < num_req) begin
                s = int'(ptr) + k;
                if (s >= num_req) begin
                    s = s - num_req;
                end
                if (valid[s[2:0]]) begin
                    rr_pick = s[2:0];
                end
            end
        end
    endfunction

endpackage

// File: rtl/act_unit_arbiter_tag_fifo.sv
// -----------------------------------------------------------------------------
// act_tag_fifo
// Synchronous FIFO holding the owner tag of every element in flight through
// the activation unit. Pushes while full and pops while empty are ignored.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_push, i_din    write request and tag
//   i_pop            read request (head advances)
//   o_dout           head tag
//   o_full, o_empty  status, derived from the registered count
//   o_count          registered occupancy
// -----------------------------------------------------------------------------
module act_tag_fifo #(
    parameter  int WIDTH = 2,
    parameter  int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Depth is a power of two, so pointers wrap naturally.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/act_unit_arbiter.sv
// -----------------------------------------------------------------------------
// act_unit_arbiter
// Round-robin arbiter sharing one element-serial activation unit between
// NUM_REQ requesters. Whole bursts (terminated by last) are granted to one
// requester; every issued element is tagged with its owner so results are
// routed back in order. Forward and return paths are purely combinational.
// Ports:
//   i_clk, i_rst                    clock, synchronous active-high reset
//   i_req_valid/data/last, o_req_ready   requester element streams
//   o_resp_valid, o_resp_data, i_resp_ready  per-requester result return
//   o_act_in_valid/data, i_act_in_ready     to activation unit
//   i_act_out_valid/data, o_act_out_ready   from activation unit
//   o_busy                          burst granted or results outstanding
// Optional (macro ACT_ARB_STATS_EN):
//   o_stat_elems  per-requester issued-element counters (32 bit, saturating)
//   o_stat_stall  cycles with act_in_valid & ~act_in_ready (saturating)
//
// State | meaning
// IDLE  | no grant; move to ARB when any requester is valid
// ARB   | pick next requester from rr_ptr; back to IDLE if requests vanished
// BURST | forward granted requester until its last element is accepted
// -----------------------------------------------------------------------------
module act_unit_arbiter
    import act_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int IN_WIDTH     = 32,
    parameter int OUT_WIDTH    = 8,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_REQ-1:0]          i_req_valid,
    input  logic [NUM_REQ*IN_WIDTH-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]          i_req_last,
    output logic [NUM_REQ-1:0]          o_req_ready,
    output logic [NUM_REQ-1:0]          o_resp_valid,
    output logic [OUT_WIDTH-1:0]        o_resp_data,
    input  logic [NUM_REQ-1:0]          i_resp_ready,
    output logic                        o_act_in_valid,
    input  logic                        i_act_in_ready,
    output logic [IN_WIDTH-1:0]         o_act_in_data,
    input  logic                        i_act_out_valid,
    input  logic [OUT_WIDTH-1:0]        i_act_out_data,
    output logic                        o_act_out_ready,
    output logic                        o_busy
`ifdef ACT_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]       o_stat_elems,
    output logic [31:0]                 o_stat_stall
`endif
);
    localparam int TAG_W = tag_width(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;

    arb_state_t          r_state;
    logic [TAG_W-1:0]    r_rr_ptr;
    logic [TAG_W-1:0]    r_grant_id;

    logic [MAX_REQ-1:0]  w_valid_ext;
    logic [2:0]          w_pick;
    logic                w_sel_valid;
    logic                w_sel_last;
    logic [IN_WIDTH-1:0] w_sel_data;
    logic                w_in_burst;
    logic                w_in_hs;
    logic                w_full;
    logic                w_empty;
    logic [TAG_W-1:0]    w_head;
    logic [CNT_W-1:0]    w_count;
    logic                w_head_ready;
    logic                w_pop;

    // Forward path: mux the granted requester onto the unit input.
    always_comb begin
        w_valid_ext                = '0;
        w_valid_ext[NUM_REQ-1:0]   = i_req_valid;
        w_sel_valid                = 1'b0;
        w_sel_last                 = 1'b0;
        w_sel_data                 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == TAG_W'(i)) begin
                w_sel_valid = i_req_valid[i];
                w_sel_last  = i_req_last[i];
                w_sel_data  = i_req_data[i*IN_WIDTH +: IN_WIDTH];
            end
        end
    end

    assign w_pick         = rr_pick(w_valid_ext, 3'(r_rr_ptr), NUM_REQ);
    assign w_in_burst     = (r_state == BURST);
    assign o_act_in_valid = w_in_burst & w_sel_valid & ~w_full;
    assign o_act_in_data  = w_sel_data;
    assign w_in_hs        = o_act_in_valid & i_act_in_ready;

    // Return path: the FIFO head names the owner of the result at the unit output.
    always_comb begin
        o_req_ready  = '0;
        o_resp_valid = '0;
        w_head_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            o_req_ready[i] = w_in_burst & (r_grant_id == TAG_W'(i))
                             & i_act_in_ready & ~w_full;
            if (w_head == TAG_W'(i)) begin
                o_resp_valid[i] = i_act_out_valid & ~w_empty;
                w_head_ready    = i_resp_ready[i];
            end
        end
    end

    assign o_resp_data     = i_act_out_data;
    assign o_act_out_ready = w_head_ready & ~w_empty;
    assign w_pop           = i_act_out_valid & o_act_out_ready;
    assign o_busy          = (r_state != IDLE) | (w_count != '0);

    act_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_in_hs),
        .i_pop   (w_pop),
        .i_din   (r_grant_id),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|i_req_valid) begin
                        r_state <= ARB;
                    end
                end
                ARB: begin
                    if (|i_req_valid) begin
                        r_grant_id <= TAG_W'(w_pick);
                        r_state    <= BURST;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                BURST: begin
                    if (w_in_hs && w_sel_last) begin
                        r_rr_ptr <= (r_grant_id == TAG_W'(NUM_REQ - 1)) ?
                                    '0 : r_grant_id + TAG_W'(1);
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ACT_ARB_STATS_EN
    logic [31:0] r_stat_elems [NUM_REQ];
    logic [31:0] r_stat_stall;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_stat_elems[i] <= '0;
            end
            r_stat_stall <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_in_hs && (r_grant_id == TAG_W'(i)) && (r_stat_elems[i] != '1)) begin
                    r_stat_elems[i] <= r_stat_elems[i] + 32'd1;
                end
            end
            if (o_act_in_valid && !i_act_in_ready && (r_stat_stall != '1)) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            o_stat_elems[i*32 +: 32] = r_stat_elems[i];
        end
    end

    assign o_stat_stall = r_stat_stall;
`endif

    // A result with no outstanding tag has no owner; it is left unacknowledged.
    a_no_orphan_result: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_act_out_valid && w_empty));

endmodule

// File: tb/tb_act_unit_arbiter.sv
module tb_act_unit_arbiter;
    localparam int N     = 4;
    localparam int IW    = 32;
    localparam int OW    = 8;
    localparam int DEPTH = 8;

    typedef struct {logic [31:0] d; bit last;} elem_t;
    typedef struct {int owner; logic [7:0] d;} exp_t;
    typedef struct {logic [7:0] d; int due;} unit_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid, req_last, req_ready, resp_valid, resp_ready;
    logic [N*IW-1:0] req_data;
    logic [OW-1:0] resp_data, act_out_data;
    logic [IW-1:0] act_in_data;
    logic          act_in_valid, act_in_ready, act_out_valid, act_out_ready, busy;

    elem_t rq[N][$];
    exp_t  sb[$];
    unit_t uq[$];
    int    grants[$];
    int    ret_order[$];
    int    issued[N];
    int    ret_cnt[N];
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc   = 0;
    int    lat   = 3;
    logic  ain_rdy = 1'b1;
    logic [N-1:0] rsp_rdy = '1;

    always #5 clk = ~clk;

    act_unit_arbiter #(.NUM_REQ(N), .IN_WIDTH(IW), .OUT_WIDTH(OW), .MAX_INFLIGHT(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .i_req_data(req_data), .i_req_last(req_last),
        .o_req_ready(req_ready),
        .o_resp_valid(resp_valid), .o_resp_data(resp_data), .i_resp_ready(resp_ready),
        .o_act_in_valid(act_in_valid), .i_act_in_ready(act_in_ready), .o_act_in_data(act_in_data),
        .i_act_out_valid(act_out_valid), .i_act_out_data(act_out_data), .o_act_out_ready(act_out_ready),
        .o_busy(busy)
    );

    task automatic add(input int r, input int v, input bit last);
        elem_t el;
        el.d = v;
        el.last = last;
        rq[r].push_back(el);
    endtask

    task automatic load(input int r, input int n, input int base);
        for (int j = 0; j < n; j++) add(r, base + j, (j == n - 1));
    endtask

    task automatic clear_log();
        grants.delete();
        ret_order.delete();
        for (int i = 0; i < N; i++) begin
            issued[i] = 0;
            ret_cnt[i] = 0;
        end
    endtask

    function automatic bit pending();
        bit p;
        p = (sb.size() > 0) || (uq.size() > 0);
        for (int i = 0; i < N; i++) if (rq[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0) begin
                req_valid[i] = 1'b1;
                req_data[i*IW +: IW] = rq[i][0].d;
                req_last[i] = rq[i][0].last;
            end else begin
                req_valid[i] = 1'b0;
                req_data[i*IW +: IW] = '0;
                req_last[i] = 1'b0;
            end
        end
        act_in_ready = ain_rdy;
        resp_ready = rsp_rdy;
        if (uq.size() > 0 && uq[0].due <= cyc) begin
            act_out_valid = 1'b1;
            act_out_data = uq[0].d;
        end else begin
            act_out_valid = 1'b0;
            act_out_data = '0;
        end
    endtask

    // One clock: monitor + scoreboard at negedge, model update after posedge.
    task automatic step();
        logic rst_s, hs_in, hs_out;
        logic [IW-1:0] in_d;
        logic [N-1:0] rhs;
        exp_t e;
        elem_t el;
        unit_t u;
        int idx;
        @(negedge clk);
        rst_s = rst;
        hs_in = act_in_valid & act_in_ready;
        in_d = act_in_data;
        hs_out = act_out_valid & act_out_ready;
        rhs = req_valid & req_ready;
        if (!rst_s) begin
            if (act_out_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL orphan_result: act_out_valid with nothing outstanding at cycle %0d", cyc);
                end else begin
                    e = sb[0];
                    n_cmp++;
                    if (resp_valid !== (4'b0001 << e.owner)) begin
                        n_err++;
                        $display("FAIL resp_route: got %b expected %b", resp_valid, 4'b0001 << e.owner);
                    end
                    n_cmp++;
                    if (resp_data !== e.d) begin
                        n_err++;
                        $display("FAIL resp_data: got %0d expected %0d", $signed(resp_data), $signed(e.d));
                    end
                    n_cmp++;
                    if (act_out_ready !== rsp_rdy[e.owner]) begin
                        n_err++;
                        $display("FAIL act_out_ready: got %b expected %b", act_out_ready, rsp_rdy[e.owner]);
                    end
                end
            end else begin
                n_cmp++;
                if (resp_valid !== '0) begin
                    n_err++;
                    $display("FAIL resp_idle: got %b expected 0000", resp_valid);
                end
            end
            if (hs_in) begin
                n_cmp++;
                if ($countones(rhs) != 1) begin
                    n_err++;
                    $display("FAIL issue_onehot: req handshakes %b expected exactly one", rhs);
                end else begin
                    idx = 0;
                    for (int i = 0; i < N; i++) if (rhs[i]) idx = i;
                    n_cmp++;
                    if (in_d !== rq[idx][0].d) begin
                        n_err++;
                        $display("FAIL act_in_data: got %0h expected %0h", in_d, rq[idx][0].d);
                    end
                end
            end else begin
                n_cmp++;
                if (rhs !== '0) begin
                    n_err++;
                    $display("FAIL req_hs_no_issue: got %b expected 0000", rhs);
                end
            end
            if (!act_in_ready) begin
                n_cmp++;
                if (req_ready !== '0) begin
                    n_err++;
                    $display("FAIL req_ready_follow: got %b expected 0000", req_ready);
                end
            end
            if (sb.size() >= DEPTH) begin
                n_cmp++;
                if (act_in_valid !== 1'b0 || req_ready !== '0) begin
                    n_err++;
                    $display("FAIL full_block: act_in_valid %b req_ready %b expected 0/0000", act_in_valid, req_ready);
                end
            end
            if (sb.size() > 0) begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL busy_inflight: got %b expected 1", busy);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst_s) begin
            sb.delete();
            uq.delete();
        end else begin
            if (hs_out && sb.size() > 0) begin
                e = sb.pop_front();
                ret_cnt[e.owner]++;
                ret_order.push_back(e.owner);
            end
            if (hs_out && uq.size() > 0) void'(uq.pop_front());
            if (hs_in) begin
                u.d = in_d[7:0] + 8'd1;
                u.due = cyc + lat;
                uq.push_back(u);
            end
            for (int i = 0; i < N; i++) begin
                if (rhs[i] && rq[i].size() > 0) begin
                    el = rq[i].pop_front();
                    e.owner = i;
                    e.d = el.d[7:0] + 8'd1;
                    sb.push_back(e);
                    issued[i]++;
                    if (el.last) grants.push_back(i);
                end
            end
        end
        drive();
    endtask

    task automatic run_drain(input string name, input int budget);
        int k = 0;
        while (pending() && k < budget) begin
            step();
            k++;
        end
        n_cmp++;
        if (pending()) begin
            n_err++;
            $display("FAIL %s_timeout: still pending after %0d cycles, expected drained", name, budget);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_log();
        add(0, 7, 1'b1);
        drive();
        do_reset();
        #1;
        n_cmp++; if (req_ready !== '0)      begin n_err++; $display("FAIL rst_req_ready: got %b expected 0000", req_ready); end
        n_cmp++; if (resp_valid !== '0)     begin n_err++; $display("FAIL rst_resp_valid: got %b expected 0000", resp_valid); end
        n_cmp++; if (act_in_valid !== 1'b0) begin n_err++; $display("FAIL rst_act_in_valid: got %b expected 0", act_in_valid); end
        n_cmp++; if (act_out_ready !== 1'b0) begin n_err++; $display("FAIL rst_act_out_ready: got %b expected 0", act_out_ready); end
        n_cmp++; if (busy !== 1'b0)         begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
        run_drain("reset_first", 100);
        n_cmp++; if (ret_cnt[0] !== 1)      begin n_err++; $display("FAIL rst_first_burst: got %0d results expected 1", ret_cnt[0]); end
    endtask

    task automatic test_single();
        clear_log();
        lat = 3;
        add(2, 5, 1'b0);
        add(2, -3, 1'b0);
        add(2, 100, 1'b0);
        add(2, 0, 1'b1);
        drive();
        run_drain("single", 200);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_fall: got %b expected 0", busy); end
        n_cmp++; if (ret_cnt[2] !== 4) begin n_err++; $display("FAIL single_count: got %0d expected 4", ret_cnt[2]); end
        n_cmp++;
        if (ret_cnt[0] + ret_cnt[1] + ret_cnt[3] !== 0) begin
            n_err++; $display("FAIL single_other: got %0d stray results expected 0", ret_cnt[0] + ret_cnt[1] + ret_cnt[3]);
        end
        // rr_ptr should now be 3: with 0 and 3 both requesting, 3 wins.
        clear_log();
        add(0, 20, 1'b1);
        add(3, 30, 1'b1);
        drive();
        run_drain("rr_ptr", 200);
        n_cmp++;
        if (grants.size() != 2) begin
            n_err++; $display("FAIL rr_ptr_grants: got %0d grants expected 2", grants.size());
        end else if (grants[0] != 3 || grants[1] != 0) begin
            n_err++; $display("FAIL rr_ptr_order: got %0d,%0d expected 3,0", grants[0], grants[1]);
        end
    endtask

    task automatic test_rr();
        do_reset();
        clear_log();
        lat = 2;
        for (int i = 0; i < N; i++) begin
            load(i, 2, 40 + 8 * i);
            load(i, 2, 44 + 8 * i);
        end
        drive();
        run_drain("rr", 400);
        n_cmp++;
        if (grants.size() != 8) begin
            n_err++; $display("FAIL rr_grant_count: got %0d expected 8", grants.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_cmp++;
                if (grants[k] != k % N) begin
                    n_err++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, grants[k], k % N);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int k;
        int saved;
        clear_log();
        lat = 3;
        load(1, 10, -60);
        drive();
        k = 0;
        while (issued[1] < 3 && k < 50) begin step(); k++; end
        n_cmp++; if (issued[1] < 3) begin n_err++; $display("FAIL bp_start: issued %0d expected >=3", issued[1]); end
        saved = issued[1];
        ain_rdy = 1'b0;
        drive();
        repeat (5) begin
            #1;
            n_cmp++; if (req_ready !== '0) begin n_err++; $display("FAIL bp_req_ready_low: got %b expected 0000", req_ready); end
            step();
        end
        n_cmp++; if (issued[1] !== saved) begin n_err++; $display("FAIL bp_no_issue: got %0d expected %0d", issued[1], saved); end
        ain_rdy = 1'b1;
        drive();
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_req_ready_high: got %b expected 0010", req_ready); end
        k = 0;
        while (!act_out_valid && k < 50) begin step(); k++; end
        n_cmp++; if (!act_out_valid) begin n_err++; $display("FAIL bp_result_wait: act_out_valid %b expected 1", act_out_valid); end
        saved = ret_cnt[1];
        rsp_rdy = '0;
        drive();
        repeat (3) begin
            #1;
            n_cmp++; if (act_out_ready !== 1'b0) begin n_err++; $display("FAIL bp_act_out_ready: got %b expected 0", act_out_ready); end
            step();
        end
        n_cmp++; if (ret_cnt[1] !== saved) begin n_err++; $display("FAIL bp_no_pop: got %0d expected %0d", ret_cnt[1], saved); end
        rsp_rdy = '1;
        drive();
        run_drain("bp", 300);
        n_cmp++; if (ret_cnt[1] !== 10) begin n_err++; $display("FAIL bp_results: got %0d expected 10", ret_cnt[1]); end
        n_cmp++; if (issued[1] !== 10)  begin n_err++; $display("FAIL bp_issued: got %0d expected 10", issued[1]); end
    endtask

    task automatic test_fifo_full();
        clear_log();
        lat = 20;
        load(3, 12, 1);
        drive();
        repeat (15) step();
        #1;
        n_cmp++; if (issued[3] !== DEPTH) begin n_err++; $display("FAIL full_issued: got %0d expected %0d", issued[3], DEPTH); end
        n_cmp++; if (req_ready !== '0)    begin n_err++; $display("FAIL full_req_ready: got %b expected 0000", req_ready); end
        n_cmp++; if (act_in_valid !== 1'b0) begin n_err++; $display("FAIL full_act_in_valid: got %b expected 0", act_in_valid); end
        run_drain("full", 600);
        n_cmp++; if (ret_cnt[3] !== 12) begin n_err++; $display("FAIL full_results: got %0d expected 12", ret_cnt[3]); end
    endtask

    task automatic test_overlap();
        int k;
        clear_log();
        lat = 10;
        load(0, 3, 70);
        drive();
        k = 0;
        while (rq[0].size() > 0 && k < 50) begin step(); k++; end
        load(1, 3, 80);
        drive();
        k = 0;
        while (issued[1] == 0 && k < 50) begin step(); k++; end
        n_cmp++; if (ret_cnt[0] >= 3) begin n_err++; $display("FAIL overlap_in_flight: got %0d returned expected <3", ret_cnt[0]); end
        run_drain("overlap", 300);
        n_cmp++;
        if (ret_order.size() != 6) begin
            n_err++; $display("FAIL overlap_count: got %0d expected 6", ret_order.size());
        end else begin
            for (int j = 0; j < 6; j++) begin
                n_cmp++;
                if (ret_order[j] != j / 3) begin
                    n_err++; $display("FAIL overlap_order[%0d]: got %0d expected %0d", j, ret_order[j], j / 3);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int k;
        clear_log();
        lat = 20;
        load(0, 8, 90);
        drive();
        k = 0;
        while (issued[0] < 5 && k < 50) begin step(); k++; end
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
        rst = 1'b1;
        step();
        #1;
        n_cmp++; if (req_ready !== '0)       begin n_err++; $display("FAIL mid_req_ready: got %b expected 0000", req_ready); end
        n_cmp++; if (act_in_valid !== 1'b0)  begin n_err++; $display("FAIL mid_act_in_valid: got %b expected 0", act_in_valid); end
        n_cmp++; if (resp_valid !== '0)      begin n_err++; $display("FAIL mid_resp_valid: got %b expected 0000", resp_valid); end
        n_cmp++; if (act_out_ready !== 1'b0) begin n_err++; $display("FAIL mid_act_out_ready: got %b expected 0", act_out_ready); end
        n_cmp++; if (busy !== 1'b0)          begin n_err++; $display("FAIL mid_busy: got %b expected 0", busy); end
        rst = 1'b0;
        load(1, 3, 110);
        drive();
        run_drain("mid", 400);
        n_cmp++; if (ret_cnt[1] !== 3) begin n_err++; $display("FAIL mid_new_burst: got %0d expected 3", ret_cnt[1]); end
        n_cmp++; if (ret_cnt[0] !== 3) begin n_err++; $display("FAIL mid_resume: got %0d expected 3", ret_cnt[0]); end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        act_in_ready = 1'b1;
        resp_ready = '1;
        act_out_valid = 1'b0;
        act_out_data = '0;
        drive();
        test_reset();
        test_single();
        test_rr();
        test_backpressure();
        test_fifo_full();
        test_overlap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
